// File: rtl/sq_mag_module_if.sv
// Settings bus, complex FFT input stream and squared-magnitude output of sq_mag_module.
interface sq_mag_module_if;
    logic               set_stb;
    logic [7:0]         set_addr;
    logic [31:0]        set_data;
    logic signed [15:0] xk_re;
    logic signed [15:0] xk_im;
    logic [9:0]         xk_index;
    logic               dv_fft;
    logic [31:0]        xk_sq_m;
    logic               dv_sq_m;
    logic               sync_lost;

    modport master (
        output set_stb, set_addr, set_data, xk_re, xk_im, xk_index, dv_fft,
        input  xk_sq_m, dv_sq_m, sync_lost
    );

    modport slave (
        input  set_stb, set_addr, set_data, xk_re, xk_im, xk_index, dv_fft,
        output xk_sq_m, dv_sq_m, sync_lost
    );
endinterface

// File: rtl/sq_mag_module.sv
// Frame-aligned, frame-decimating |X[k]|^2 stage feeding the energy detector.
// States: HUNT | wait for index 0 ; PASS | forward frame ; SKIP | discard decimated frames
module setting_reg #(
    parameter logic [7:0]       ADDR  = 8'd0,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            out <= INIT;
        else if (set_stb && set_addr == ADDR)
            out <= data;
    end
endmodule

module sq_mag_module #(
    parameter logic [7:0] ADDR_LEN = 8'd4,
    parameter logic [7:0] ADDR_DEC = 8'd5
) (
    input  logic            clock,
    input  logic            reset,
    sq_mag_module_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, PASS, SKIP} state_t;

    logic [3:0] len_reg, len_new, len_w;
    logic [7:0] dec_reg, dec_new, dec_w;
    logic       unused_set_data;

    setting_reg #(.ADDR(ADDR_LEN), .WIDTH(4), .INIT(4'd10)) u_len (
        .clock(clock), .reset(reset), .set_stb(bus.set_stb), .set_addr(bus.set_addr),
        .data(bus.set_data[3:0]), .out(len_reg)
    );

    setting_reg #(.ADDR(ADDR_DEC), .WIDTH(8), .INIT(8'd1)) u_dec (
        .clock(clock), .reset(reset), .set_stb(bus.set_stb), .set_addr(bus.set_addr),
        .data(bus.set_data[7:0]), .out(dec_reg)
    );

    assign unused_set_data = &{1'b0, bus.set_data[31:8]};

    always_comb begin
        len_new = len_reg;
        if (len_reg < 4'd4)
            len_new = 4'd4;
        else if (len_reg > 4'd10)
            len_new = 4'd10;
        dec_new = (dec_reg == 8'd0) ? 8'd1 : dec_reg;
    end

    state_t             state;
    logic [9:0]         exp_idx, last_idx;
    logic [7:0]         fcnt, fcnt_inc;
    logic               v1, v2;
    logic signed [15:0] re1, im1;
    logic signed [31:0] re_sq, im_sq;

    assign last_idx = 10'((11'd1 << len_w) - 11'd1);
    assign fcnt_inc = fcnt + 8'd1;

    // Frame tracking plus pipeline stage 1 (input capture and forward decision).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            exp_idx       <= '0;
            fcnt          <= '0;
            len_w         <= 4'd10;
            dec_w         <= 8'd1;
            v1            <= 1'b0;
            re1           <= '0;
            im1           <= '0;
            bus.sync_lost <= 1'b0;
        end else begin
            v1            <= 1'b0;
            bus.sync_lost <= 1'b0;
            re1           <= bus.xk_re;
            im1           <= bus.xk_im;
            if (bus.dv_fft) begin
                unique case (state)
                    HUNT: begin
                        if (bus.xk_index == 10'd0) begin
                            state   <= PASS;
                            v1      <= 1'b1;
                            len_w   <= len_new;
                            dec_w   <= dec_new;
                            fcnt    <= '0;
                            exp_idx <= 10'd1;
                        end
                    end
                    PASS, SKIP: begin
                        if (bus.xk_index != exp_idx) begin
                            state         <= HUNT;
                            bus.sync_lost <= 1'b1;
                        end else begin
                            v1      <= (state == PASS);
                            exp_idx <= exp_idx + 10'd1;
                            if (bus.xk_index == last_idx) begin
                                exp_idx <= '0;
                                if (state == PASS) begin
                                    if (dec_w > 8'd1) begin
                                        state <= SKIP;
                                    end else begin
                                        len_w <= len_new;
                                        dec_w <= dec_new;
                                    end
                                end else if (fcnt_inc == dec_w - 8'd1) begin
                                    fcnt  <= '0;
                                    state <= PASS;
                                    len_w <= len_new;
                                    dec_w <= dec_new;
                                end else begin
                                    fcnt <= fcnt_inc;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // Stages 2 and 3: squares, then their sum; the sum cannot exceed 2^31.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v2          <= 1'b0;
            re_sq       <= '0;
            im_sq       <= '0;
            bus.dv_sq_m <= 1'b0;
            bus.xk_sq_m <= '0;
        end else begin
            v2          <= v1;
            re_sq       <= re1 * re1;
            im_sq       <= im1 * im1;
            bus.dv_sq_m <= v2;
            if (v2)
                bus.xk_sq_m <= $unsigned(re_sq) + $unsigned(im_sq);
        end
    end
endmodule
